// File: rtl/and_unit_arbiter_if.sv
// Bundle of the requester-side and consumer-side signals of the shared
// AND-unit arbiter. The arbiter connects through the slave modport; the
// requesting logic and result consumer connect through the master modport.
interface and_unit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_y;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_y,
        input  rsp_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_y,
        output rsp_id,
        output busy
    );
endinterface

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit bitwise-AND unit among
// NUM_REQ requesters. One transaction is in flight at a time:
//   IDLE : pick a winner starting at ptr, accept its operands
//   EXEC : compute a & b in the shared unit and register the result
//   RESP : hold the tagged result until the consumer takes it
// ptr advances to the slot after the served requester only when the
// response is consumed, so a continuously valid requester is served
// within NUM_REQ transactions.
module and_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    and_unit_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   rsp_y_r;
    logic               rsp_valid_r;
    logic               busy_r;

    logic [ID_W-1:0]    winner_s;
    logic [ID_W-1:0]    cand_s;
    logic               found_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic               accept_s;
    logic               release_s;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && bus.req_valid[cand_s]) begin
                winner_s = cand_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Operand mux: pick the winner's slices out of the packed buses.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                sel_a_s = bus.req_a[i*WIDTH +: WIDTH];
                sel_b_s = bus.req_b[i*WIDTH +: WIDTH];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Grant is offered only while idle; one-hot on the winner, else zero.
    always_comb begin
        grant_s = '0;
        if ((state_r == IDLE) && found_s) begin
            grant_s[winner_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign accept_s  = (state_r == IDLE) && found_s;
    assign release_s = (state_r == RESP) && bus.rsp_ready;

    // Next-state decode for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the winner's operands and ID on the handshake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            id_r <= '0;
        end else if (accept_s) begin
            a_r  <= sel_a_s;
            b_r  <= sel_b_s;
            id_r <= winner_s;
        end else begin
            a_r  <= a_r;
            b_r  <= b_r;
            id_r <= id_r;
        end
    end

    // Advance the round-robin pointer past the served requester on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (release_s) begin
            ptr_r <= (id_r == LAST_ID) ? '0 : (id_r + ID_W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Shared AND unit: result and tag are registered in EXEC and held in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_y_r  <= '0;
            rsp_id_r <= '0;
        end else if (state_r == EXEC) begin
            rsp_y_r  <= a_r & b_r;
            rsp_id_r <= id_r;
        end else begin
            rsp_y_r  <= rsp_y_r;
            rsp_id_r <= rsp_id_r;
        end
    end

    // Response valid: rises entering RESP, falls when the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_valid_r <= 1'b1;
        end else if (release_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Busy flag mirrors "not IDLE" as a registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    assign bus.req_ready = grant_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_y     = rsp_y_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Directed bench for the shared AND-unit arbiter (NUM_REQ=4, WIDTH=4).
module tb_and_unit_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [3:0] pat [4];

    and_unit_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bif ();

    and_unit_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b);
        bif.req_a[i*4 +: 4] = a;
        bif.req_b[i*4 +: 4] = b;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bif.req_valid = 4'b0000;
        bif.req_a     = 16'h0000;
        bif.req_b     = 16'h0000;
        bif.rsp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({bif.req_ready, bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b y=%b id=%0d busy=%b exp all 0",
                     bif.req_ready, bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy got=%b exp=0", bif.busy);
        end
    endtask

    task automatic test_single();
        set_req(1, 4'b1010, 4'b0110);
        bif.req_valid = 4'b0010;
        bif.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0010", bif.req_ready);
        end
        tick();
        bif.req_valid = 4'b0000;
        #1;
        checks++;
        if ({bif.req_ready, bif.rsp_valid, bif.busy} !== 6'b0000_01) begin
            failures++;
            $display("FAIL single_exec got ready=%b valid=%b busy=%b exp 0000/0/1",
                     bif.req_ready, bif.rsp_valid, bif.busy);
        end
        tick();
        checks++;
        if ({bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy} !== {1'b1, 4'b0010, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL single_resp got valid=%b y=%b id=%0d busy=%b exp 1/0010/1/1",
                     bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy);
        end
        tick();
        checks++;
        if ({bif.rsp_valid, bif.busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_done got valid=%b busy=%b exp 0/0", bif.rsp_valid, bif.busy);
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 4'b1111, pat[i]);
        bif.req_valid = 4'b1111;
        bif.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bif.req_ready !== (4'b0001 << (k % 4))) begin
                failures++;
                $display("FAIL rr_grant[%0d] got=%b exp=%b", k, bif.req_ready, 4'b0001 << (k % 4));
            end
            tick();
            checks++;
            if (bif.req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL rr_exec_ready[%0d] got=%b exp=0000", k, bif.req_ready);
            end
            tick();
            checks++;
            if ({bif.rsp_valid, bif.rsp_id, bif.rsp_y} !== {1'b1, 2'(k % 4), pat[k % 4]}) begin
                failures++;
                $display("FAIL rr_resp[%0d] got valid=%b id=%0d y=%b exp 1/%0d/%b",
                         k, bif.rsp_valid, bif.rsp_id, bif.rsp_y, k % 4, pat[k % 4]);
            end
            tick();
        end
        bif.req_valid = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] masks [4];
        int         ids   [4];
        masks = '{4'b1000, 4'b0101, 4'b0101, 4'b1010};
        ids   = '{3, 0, 2, 3};
        for (int k = 0; k < 4; k++) begin
            bif.req_valid = masks[k];
            #1;
            checks++;
            if (bif.req_ready !== (4'b0001 << ids[k])) begin
                failures++;
                $display("FAIL fair_grant[%0d] got=%b exp=%b", k, bif.req_ready, 4'b0001 << ids[k]);
            end
            tick();
            bif.req_valid = 4'b0000;
            tick();
            checks++;
            if ({bif.rsp_valid, bif.rsp_id, bif.rsp_y} !== {1'b1, 2'(ids[k]), pat[ids[k]]}) begin
                failures++;
                $display("FAIL fair_resp[%0d] got valid=%b id=%0d y=%b exp 1/%0d/%b",
                         k, bif.rsp_valid, bif.rsp_id, bif.rsp_y, ids[k], pat[ids[k]]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        set_req(2, 4'b1100, 4'b1010);
        set_req(3, 4'b1111, 4'b1000);
        bif.req_valid = 4'b0100;
        bif.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=0100", bif.req_ready);
        end
        tick();
        bif.req_valid = 4'b1111;
        bif.rsp_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.req_ready} !== {1'b1, 4'b1000, 2'd2, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b y=%b id=%0d ready=%b exp 1/1000/2/0000",
                         c, bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.req_ready);
            end
            tick();
        end
        bif.rsp_ready = 1'b1;
        tick();
        checks++;
        if ({bif.rsp_valid, bif.req_ready} !== 5'b0_1000) begin
            failures++;
            $display("FAIL bp_release got valid=%b ready=%b exp 0/1000", bif.rsp_valid, bif.req_ready);
        end
        tick();
        bif.req_valid = 4'b0000;
        tick();
        checks++;
        if ({bif.rsp_valid, bif.rsp_id, bif.rsp_y} !== {1'b1, 2'd3, 4'b1000}) begin
            failures++;
            $display("FAIL bp_next got valid=%b id=%0d y=%b exp 1/3/1000",
                     bif.rsp_valid, bif.rsp_id, bif.rsp_y);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        set_req(2, 4'b1111, 4'b0101);
        set_req(3, 4'b0011, 4'b0001);
        bif.req_valid = 4'b0100;
        bif.rsp_ready = 1'b1;
        tick();
        bif.req_valid = 4'b0000;
        tick();
        tick();
        bif.req_valid = 4'b1000;
        tick();
        bif.req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bif.req_ready, bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy} !== 12'h000) begin
            failures++;
            $display("FAIL midop_async got ready=%b valid=%b y=%b id=%0d busy=%b exp all 0",
                     bif.req_ready, bif.rsp_valid, bif.rsp_y, bif.rsp_id, bif.busy);
        end
        tick();
        tick();
        checks++;
        if ({bif.rsp_valid, bif.busy} !== 2'b00) begin
            failures++;
            $display("FAIL midop_hold got valid=%b busy=%b exp 0/0", bif.rsp_valid, bif.busy);
        end
        rst_n = 1'b1;
        bif.req_valid = 4'b1100;
        #1;
        checks++;
        if (bif.req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL midop_ptr got=%b exp=0100", bif.req_ready);
        end
        tick();
        bif.req_valid = 4'b0000;
        tick();
        checks++;
        if ({bif.rsp_valid, bif.rsp_id, bif.rsp_y} !== {1'b1, 2'd2, 4'b0101}) begin
            failures++;
            $display("FAIL midop_resp got valid=%b id=%0d y=%b exp 1/2/0101",
                     bif.rsp_valid, bif.rsp_id, bif.rsp_y);
        end
        tick();
    endtask

    task automatic test_sweep();
        bif.rsp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                set_req(0, 4'(a), 4'(b));
                bif.req_valid = 4'b0001;
                tick();
                bif.req_valid = 4'b0000;
                tick();
                checks++;
                if ({bif.rsp_valid, bif.rsp_id, bif.rsp_y} !== {1'b1, 2'd0, 4'(a & b)}) begin
                    failures++;
                    $display("FAIL sweep a=%b b=%b got valid=%b id=%0d y=%b exp 1/0/%b",
                             4'(a), 4'(b), bif.rsp_valid, bif.rsp_id, bif.rsp_y, 4'(a & b));
                end
                tick();
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pat[0]   = 4'b0001;
        pat[1]   = 4'b0010;
        pat[2]   = 4'b0100;
        pat[3]   = 4'b1000;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_reset_midop();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
